// File: rtl/mem_xfer_ctrl.sv
// Sequencer moving words between a register's memory-side port and a synchronous data RAM.
// Optional MEM_XFER_AUTOINC_EN: address register post-increments at the end of every transfer.
module mem_xfer_ctrl #(
  parameter int width       = 16,
  parameter int addr_width  = 16,
  parameter int mem_latency = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic                  ld_addr,
  input  logic                  inc_addr,
  input  logic [addr_width-1:0] addr_in,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [width-1:0]      mem_wdata,
  input  logic [width-1:0]      mem_rdata,
  output logic                  reg_rM,
  input  logic [width-1:0]      reg_Mdout,
  output logic                  reg_wM,
  output logic [width-1:0]      reg_Mdin
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] RD_LOAD  = 3'd3;
  localparam logic [2:0] WR_FETCH = 3'd4;
  localparam logic [2:0] WR_ISSUE = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);
  localparam logic [3:0]            LAT     = 4'(mem_latency);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [3:0]            wait_cnt;
  logic [addr_width-1:0] addr;
  logic [width-1:0]      data_reg;
  logic [width-1:0]      wdata_reg;

  // Read wins over write when both requests arrive in the same IDLE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_rd)
          next_state = RD_ISSUE;
        else if (req_wr)
          next_state = WR_FETCH;
      end
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT: begin
        if (wait_cnt == 4'd1)
          next_state = RD_LOAD;
      end
      RD_LOAD:  next_state = DONE;
      WR_FETCH: next_state = WR_ISSUE;
      WR_ISSUE: next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      data_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state <= next_state;
      case (state)
        RD_ISSUE: wait_cnt <= LAT;
        RD_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1)
            data_reg <= mem_rdata;
        end
        WR_FETCH: wdata_reg <= reg_Mdout;
        default: ;
      endcase
    end
  end

  // Address is only steerable by the control unit while idle, so a transfer's address never moves under it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (state == IDLE) begin
      if (ld_addr)
        addr <= addr_in;
      else if (inc_addr)
        addr <= addr + ADDR_ONE;
    end
`ifdef MEM_XFER_AUTOINC_EN
    else if (state == DONE) begin
      addr <= addr + ADDR_ONE;
    end
`else
    else begin
      addr <= addr;
    end
`endif
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_addr  = addr;
  assign mem_re    = (state == RD_ISSUE);
  assign mem_we    = (state == WR_ISSUE);
  assign mem_wdata = wdata_reg;
  assign reg_rM    = (state == WR_FETCH);
  assign reg_wM    = (state == RD_LOAD);
  assign reg_Mdin  = data_reg;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed self-checking bench for mem_xfer_ctrl with a latency-accurate RAM model.
// Expectations follow MEM_XFER_AUTOINC_EN when it is defined for the build.
module tb_mem_xfer_ctrl;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic        ld_addr = 1'b0;
  logic        inc_addr = 1'b0;
  logic [15:0] addr_in = 16'h0;
  logic        busy, done, mem_re, mem_we, reg_rM, reg_wM;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, reg_Mdout, reg_Mdin;

  logic [15:0] ramData = 16'h0;
  logic [15:0] regValue = 16'h0;
  logic [15:0] rePipe = 16'h0;

  int errors = 0;
  int checks = 0;

`ifdef MEM_XFER_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  mem_xfer_ctrl #(.width(16), .addr_width(16), .mem_latency(L)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
    .ld_addr(ld_addr), .inc_addr(inc_addr), .addr_in(addr_in),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_rM(reg_rM), .reg_Mdout(reg_Mdout), .reg_wM(reg_wM), .reg_Mdin(reg_Mdin)
  );

  always #5 clk = ~clk;

  // RAM returns valid data only in the cycle exactly L cycles after the mem_re cycle.
  always @(posedge clk) rePipe <= {rePipe[14:0], mem_re};
  assign mem_rdata = rePipe[L-1] ? ramData : 16'hDEAD;
  assign reg_Mdout = reg_rM ? regValue : 16'h0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    obs = {mem_re, mem_we, reg_rM, reg_wM, done, busy};
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL reset_strobes got=%b expected=000000", obs);
    end
    checks++;
    if (mem_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_addr got=%h expected=0000", mem_addr);
    end
    checks++;
    if (mem_wdata !== 16'h0000 || reg_Mdin !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data got wdata=%h mdin=%h expected 0000/0000", mem_wdata, reg_Mdin);
    end
  endtask

  // Load and read request in the same cycle: the read must use the new address.
  task automatic test_read();
    logic [5:0] exp [1:6];
    logic [5:0] obs;
    exp[1] = 6'b100001; exp[2] = 6'b000001; exp[3] = 6'b000001;
    exp[4] = 6'b000101; exp[5] = 6'b000011; exp[6] = 6'b000000;
    ramData = 16'hBEEF;
    ld_addr = 1'b1; addr_in = 16'h0040; req_rd = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      ld_addr = 1'b0; req_rd = 1'b0;
      obs = {mem_re, mem_we, reg_rM, reg_wM, done, busy};
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("[TB] FAIL read_cycle%0d got=%b expected=%b", c, obs, exp[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 16'h0040) begin
          errors++;
          $display("[TB] FAIL read_addr got=%h expected=0040", mem_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if (reg_Mdin !== 16'hBEEF) begin
          errors++;
          $display("[TB] FAIL read_mdin got=%h expected=beef", reg_Mdin);
        end
      end
    end
    checks++;
    if (mem_addr !== (AUTOINC ? 16'h0041 : 16'h0040)) begin
      errors++;
      $display("[TB] FAIL read_addr_after got=%h expected=%h", mem_addr, AUTOINC ? 16'h0041 : 16'h0040);
    end
  endtask

  // Address controls and a second request during the transfer must be ignored.
  task automatic test_write();
    logic [5:0] exp [1:5];
    logic [5:0] obs;
    exp[1] = 6'b001001; exp[2] = 6'b010001; exp[3] = 6'b000011;
    exp[4] = 6'b000000; exp[5] = 6'b000000;
    ld_addr = 1'b1; addr_in = 16'h0041;
    tick();
    ld_addr = 1'b0;
    regValue = 16'h1234;
    req_wr = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      req_wr = 1'b0;
      if (c == 1) begin
        ld_addr = 1'b1; addr_in = 16'h0999; inc_addr = 1'b1; req_rd = 1'b1;
      end else if (c == 2) begin
        req_rd = 1'b1;
      end else begin
        ld_addr = 1'b0; inc_addr = 1'b0; req_rd = 1'b0;
      end
      obs = {mem_re, mem_we, reg_rM, reg_wM, done, busy};
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("[TB] FAIL write_cycle%0d got=%b expected=%b", c, obs, exp[c]);
      end
      if (c == 2) begin
        checks++;
        if (mem_wdata !== 16'h1234 || mem_addr !== 16'h0041) begin
          errors++;
          $display("[TB] FAIL write_data got data=%h addr=%h expected 1234/0041", mem_wdata, mem_addr);
        end
      end
    end
    checks++;
    if (mem_addr !== (AUTOINC ? 16'h0042 : 16'h0041)) begin
      errors++;
      $display("[TB] FAIL write_addr_after got=%h expected=%h", mem_addr, AUTOINC ? 16'h0042 : 16'h0041);
    end
  endtask

  task automatic test_both_requests();
    logic [5:0] exp [1:6];
    logic [5:0] obs;
    exp[1] = 6'b100001; exp[2] = 6'b000001; exp[3] = 6'b000001;
    exp[4] = 6'b000101; exp[5] = 6'b000011; exp[6] = 6'b000000;
    ramData = 16'h5A5A;
    regValue = 16'h7777;
    ld_addr = 1'b1; addr_in = 16'h0010; req_rd = 1'b1; req_wr = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      ld_addr = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
      obs = {mem_re, mem_we, reg_rM, reg_wM, done, busy};
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("[TB] FAIL both_cycle%0d got=%b expected=%b", c, obs, exp[c]);
      end
    end
    checks++;
    if (reg_Mdin !== 16'h5A5A || mem_wdata !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL both_data got mdin=%h wdata=%h expected 5a5a/1234", reg_Mdin, mem_wdata);
    end
  endtask

  task automatic test_addr_ops();
    ld_addr = 1'b1; inc_addr = 1'b1; addr_in = 16'h0200;
    tick();
    ld_addr = 1'b0;
    checks++;
    if (mem_addr !== 16'h0200) begin
      errors++;
      $display("[TB] FAIL addr_ld_priority got=%h expected=0200", mem_addr);
    end
    tick();
    inc_addr = 1'b0;
    checks++;
    if (mem_addr !== 16'h0201) begin
      errors++;
      $display("[TB] FAIL addr_inc got=%h expected=0201", mem_addr);
    end
    ld_addr = 1'b1; addr_in = 16'hFFFF;
    tick();
    ld_addr = 1'b0; inc_addr = 1'b1;
    tick();
    inc_addr = 1'b0;
    checks++;
    if (mem_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL addr_inc_wrap got=%h expected=0000", mem_addr);
    end
  endtask

  task automatic test_autoinc_wrap();
    ramData = 16'h0F0F;
    ld_addr = 1'b1; addr_in = 16'hFFFF;
    tick();
    ld_addr = 1'b0; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    for (int c = 2; c <= 6; c++) tick();
    checks++;
    if (mem_addr !== (AUTOINC ? 16'h0000 : 16'hFFFF)) begin
      errors++;
      $display("[TB] FAIL autoinc_wrap got=%h expected=%h", mem_addr, AUTOINC ? 16'h0000 : 16'hFFFF);
    end
    checks++;
    if (reg_Mdin !== 16'h0F0F) begin
      errors++;
      $display("[TB] FAIL autoinc_read_data got=%h expected=0f0f", reg_Mdin);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [5:0] obs;
    int pulses;
    ramData = 16'h9999;
    ld_addr = 1'b1; addr_in = 16'h0123; req_rd = 1'b1;
    tick();
    ld_addr = 1'b0; req_rd = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {mem_re, mem_we, reg_rM, reg_wM, done, busy};
    checks++;
    if (obs !== 6'b000000 || mem_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_state got=%b addr=%h expected 000000/0000", obs, mem_addr);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (reg_wM === 1'b1 || done === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet got=%0d active cycles expected=0", pulses);
    end
    checks++;
    if (reg_Mdin !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_data got=%h expected=0000", reg_Mdin);
    end
  endtask

  task automatic test_back_to_back();
    ld_addr = 1'b1; addr_in = 16'h0030;
    tick();
    ld_addr = 1'b0;
    regValue = 16'hAAAA; req_wr = 1'b1;
    tick();
    req_wr = 1'b0;
    tick();
    tick();
    req_rd = 1'b1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_done got=%b expected=1", done);
    end
    tick();
    req_rd = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle got busy=%b re=%b expected 0/0", busy, mem_re);
    end
    regValue = 16'h5555; req_wr = 1'b1;
    tick();
    req_wr = 1'b0;
    checks++;
    if (reg_rM !== 1'b1 || busy !== 1'b1 || mem_re !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second_fetch got rM=%b busy=%b re=%b expected 1/1/0", reg_rM, busy, mem_re);
    end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL b2b_second_write got we=%b data=%h expected 1/5555", mem_we, mem_wdata);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_both_requests();
    test_addr_ops();
    test_autoinc_wrap();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
